// File: rtl/layer_compositor.sv
// Two-stage priority layer compositor with frame-based blink phase.
// Optional per-layer win statistics enabled by LAYER_COMP_STATS_EN.
module layer_compositor #(
  parameter int NUM_LAYERS   = 6,
  parameter int ADDR_W       = 17,
  parameter int BLINK_FRAMES = 30,
  parameter int CNT_W        = 19,
  localparam int LID_W       = (NUM_LAYERS > 2) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         pix_valid_i,
  input  logic [NUM_LAYERS-1:0]        layer_hit_i,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr_i,
  input  logic [NUM_LAYERS-1:0]        layer_en_i,
  input  logic [NUM_LAYERS-1:0]        blink_mask_i,
  input  logic                         frame_tick_i,
  output logic [ADDR_W-1:0]            pixel_addr_o,
  output logic                         not_blank_o,
  output logic [LID_W-1:0]             layer_id_o,
  output logic                         out_valid_o,
  output logic                         blink_phase_o
`ifdef LAYER_COMP_STATS_EN
  ,
  input  logic [LID_W-1:0]             stat_sel_i,
  output logic [CNT_W-1:0]             stat_count_o
`endif
);

  logic                         s1_valid_q;
  logic [NUM_LAYERS-1:0]        s1_hit_q;
  logic [NUM_LAYERS*ADDR_W-1:0] s1_addr_q;

  logic [ADDR_W-1:0]            pix_addr_q;
  logic [LID_W-1:0]             layer_id_q;
  logic                         not_blank_q;
  logic                         out_valid_q;

  logic [7:0]                   frame_cnt_q;
  logic                         blink_phase_q;

  logic [NUM_LAYERS-1:0]        eff_hit;
  logic                         win_found;
  logic [LID_W-1:0]             win_id;
  logic [ADDR_W-1:0]            win_addr;

  // Uses the registered phase, so a pixel arriving with frame_tick sees the pre-tick phase.
  assign eff_hit = layer_hit_i & layer_en_i & ~(blink_mask_i & {NUM_LAYERS{~blink_phase_q}});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= pix_valid_i;
      s1_hit_q   <= eff_hit;
      s1_addr_q  <= layer_addr_i;
    end
  end

  // Descending scan so the lowest hitting index is the last assignment and wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        win_found = 1'b1;
        win_id    = LID_W'(i);
        win_addr  = s1_addr_q[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix_addr_q  <= '0;
      layer_id_q  <= '0;
      not_blank_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q && win_found) begin
        pix_addr_q  <= win_addr;
        layer_id_q  <= win_id;
        not_blank_q <= 1'b1;
      end else begin
        pix_addr_q  <= '0;
        layer_id_q  <= '0;
        not_blank_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick_i) begin
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign pixel_addr_o  = pix_addr_q;
  assign layer_id_o    = layer_id_q;
  assign not_blank_o   = not_blank_q;
  assign out_valid_o   = out_valid_q;
  assign blink_phase_o = blink_phase_q;

`ifdef LAYER_COMP_STATS_EN
  logic [CNT_W-1:0] live_q [NUM_LAYERS];
  logic [CNT_W-1:0] snap_q [NUM_LAYERS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (frame_tick_i) begin
          snap_q[i] <= live_q[i];
          live_q[i] <= (out_valid_q && not_blank_q && layer_id_q == LID_W'(i)) ? CNT_W'(1) : '0;
        end else if (out_valid_q && not_blank_q && layer_id_q == LID_W'(i) && live_q[i] != '1) begin
          live_q[i] <= live_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    stat_count_o = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (stat_sel_i == LID_W'(i)) stat_count_o = snap_q[i];
    end
  end
`endif

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 6, number of layers; index 0 has highest priority; legal range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 17, width of each layer pixel address.
REQ-003 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period; legal range 1..255.
REQ-004 SHALL have parameter CNT_W, default 19, width of per-layer statistics counters.
REQ-005 SHALL define LID_W = clog2(NUM_LAYERS), minimum 1.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 pix_valid  input  1  current layer inputs are valid for one pixel.
REQ-009 layer_hit  input  NUM_LAYERS  bit i: layer i covers the current pixel.
REQ-010 layer_addr  input  NUM_LAYERS*ADDR_W  layer i address at bits [i*ADDR_W +: ADDR_W].
REQ-011 layer_en  input  NUM_LAYERS  bit i: layer i is enabled.
REQ-012 blink_mask  input  NUM_LAYERS  bit i: layer i blinks.
REQ-013 frame_tick  input  1  one-cycle pulse at frame start.
REQ-014 pixel_addr  output  ADDR_W  address of the winning layer.
REQ-015 notBlank  output  1  a layer won the pixel.
REQ-016 layer_id  output  LID_W  index of the winning layer.
REQ-017 out_valid  output  1  outputs correspond to an accepted pixel.
REQ-018 blink_phase  output  1  1 = blinking layers visible.
REQ-019 stat_sel  input  LID_W  layer whose statistic is read; present only with LAYER_COMP_STATS_EN.
REQ-020 stat_count  output  CNT_W  snapshot win count of layer stat_sel; present only with LAYER_COMP_STATS_EN.

Function
REQ-021 Stage 1 SHALL register pix_valid, layer_addr and eff_hit = layer_hit & layer_en & ~(blink_mask & {NUM_LAYERS{~blink_phase}}).
REQ-022 Stage 2 SHALL select the lowest index i with eff_hit[i]=1 and register pixel_addr, layer_id = i, notBlank = 1 and out_valid.
REQ-023 Latency from pix_valid to out_valid SHALL be exactly 2 cycles, at full throughput of one pixel per cycle with no stalls.
REQ-024 With no effective hit, or with stage-1 valid low, stage 2 SHALL drive pixel_addr = 0, layer_id = 0 and notBlank = 0.
REQ-025 out_valid SHALL equal the stage-1 valid; notBlank = 1 only when out_valid = 1.
REQ-026 Frame counter (8 bits) SHALL increment on frame_tick; on reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase on the same tick.
REQ-027 BLINK_FRAMES = 1 SHALL toggle blink_phase on every frame_tick.
REQ-028 A pixel accepted in the same cycle as frame_tick SHALL use the pre-tick blink_phase.
REQ-029 layer_en and blink_mask SHALL be sampled with the pixel (stage 1) and SHALL have no effect on pixels already in flight.

Reset
REQ-030 rst = 0 SHALL asynchronously clear both pipeline stages: pixel_addr = 0, layer_id = 0, notBlank = 0, out_valid = 0.
REQ-031 rst = 0 SHALL set the frame counter to 0 and blink_phase to 1, and clear all statistics registers.
REQ-032 Pixels in flight during reset SHALL be discarded; the first valid output SHALL appear 2 cycles after the first pix_valid following release.

Configuration
REQ-033 Macro LAYER_COMP_STATS_EN defined: one live CNT_W counter per layer SHALL increment when that layer wins a stage-2 output with out_valid = 1, saturating at 2^CNT_W-1.
REQ-034 With LAYER_COMP_STATS_EN defined, frame_tick SHALL copy every live counter to its snapshot register and restart it; a win in the tick cycle SHALL restart that counter at 1, otherwise at 0.
REQ-035 With LAYER_COMP_STATS_EN defined, stat_count SHALL equal snapshot[stat_sel] combinationally, and 0 when stat_sel >= NUM_LAYERS.
REQ-036 Macro LAYER_COMP_STATS_EN undefined: stat_sel, stat_count and all counters SHALL be absent; all other behaviour identical.

Verification
REQ-037 Priority: hit=6'b101100, en all 1, addr[2]=100, addr[3]=200 -> 2 cycles later pixel_addr=100, layer_id=2, notBlank=1.
REQ-038 Enable/blank: hit=6'b000100, en[2]=0 -> notBlank=0, pixel_addr=0, out_valid=1; pix_valid=0 -> out_valid=0.
REQ-039 Blink: BLINK_FRAMES=2, blink_mask[0]=1, hit={0,1} both -> after 2 frame_ticks layer_id=1; after 4 ticks layer_id=0.
REQ-040 Streaming: 8 consecutive pix_valid pixels with distinct addresses -> 8 consecutive out_valid cycles, same order, latency 2.
REQ-041 Reset mid-stream: rst low for 1 cycle with 2 pixels in flight -> outputs 0 immediately, blink_phase=1, no stale out_valid.
REQ-042 Stats (LAYER_COMP_STATS_EN): 5 wins by layer 3 then frame_tick -> stat_sel=3 gives stat_count=5; live counter restarts.
